// File: rtl/seq_det_event_logger_if.sv
// seq_det_event_logger_if: control, detection and FIFO read-port signals of the event logger.
interface seq_det_event_logger_if #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    logic                   en;
    logic                   clr;
    logic                   det_in;
    logic                   rd_ready;
    logic                   rd_valid;
    logic [TS_W-1:0]        rd_data;
    logic [$clog2(DEPTH):0] fill;
    logic [CNT_W-1:0]       count;
    logic                   overflow;

    modport master (
        output en, clr, det_in, rd_ready,
        input  rd_valid, rd_data, fill, count, overflow
    );

    modport slave (
        input  en, clr, det_in, rd_ready,
        output rd_valid, rd_data, fill, count, overflow
    );
endinterface

// File: rtl/seq_det_event_logger.sv
// seq_det_event_logger: timestamps detector pulses into a first-word-fall-through FIFO with saturating count and sticky overflow.
// Define SEQDET_LOG_GAP_EN to log inter-detection gaps instead of absolute timestamps.
module seq_det_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    seq_det_event_logger_if.slave log_if
);
    localparam int AW = $clog2(DEPTH);

    logic [TS_W-1:0]  ts_q, ts_d, entry;
    logic [TS_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]      fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, cap, pop, push;

    // A capture into a full FIFO still lands when the head leaves on the same edge.
    always_comb begin
        cap    = log_if.en && log_if.det_in && !log_if.clr;
        pop    = fill_q != '0 && log_if.rd_ready && !log_if.clr;
        push   = cap && (fill_q != (AW+1)'(DEPTH) || pop);
        ts_d   = log_if.clr ? '0 : ts_q + TS_W'(log_if.en);
        wp_d   = log_if.clr ? '0 : wp_q + AW'(push);
        rp_d   = log_if.clr ? '0 : rp_q + AW'(pop);
        fill_d = log_if.clr ? '0 : fill_q + (AW+1)'(push) - (AW+1)'(pop);
        cnt_d  = log_if.clr ? '0 : cnt_q + CNT_W'(cap && cnt_q != '1);
        ovf_d  = !log_if.clr && (ovf_q || (cap && !push));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ts_q   <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ts_q   <= ts_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) mem_q[wp_q] <= entry;
    end

`ifdef SEQDET_LOG_GAP_EN
    logic [TS_W-1:0] gap_q, gap_d;

    assign gap_d = log_if.clr ? '0 : cap ? TS_W'(1) : gap_q + TS_W'(log_if.en && gap_q != '1);
    assign entry = gap_q;

    always_ff @(posedge clk) begin
        gap_q <= !rst ? '0 : gap_d;
    end
`else
    assign entry = ts_q;
`endif

    assign log_if.rd_valid = fill_q != '0;
    assign log_if.rd_data  = fill_q != '0 ? mem_q[rp_q] : '0;
    assign log_if.fill     = fill_q;
    assign log_if.count    = cnt_q;
    assign log_if.overflow = ovf_q;
endmodule

// File: tb/tb_seq_det_event_logger.sv
// tb_seq_det_event_logger: vector table plus scoreboard for the default logger, and a narrow instance for wrap/saturation.
module tb_seq_det_event_logger;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seq_det_event_logger_if #(.TS_W(16), .DEPTH(8), .CNT_W(16)) b0 ();
    seq_det_event_logger_if #(.TS_W(4),  .DEPTH(4), .CNT_W(2))  b1 ();

    seq_det_event_logger #(.TS_W(16), .DEPTH(8), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .log_if(b0));
    seq_det_event_logger #(.TS_W(4),  .DEPTH(4), .CNT_W(2))  u1 (.clk(clk), .rst(rst), .log_if(b1));

`ifdef SEQDET_LOG_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    typedef struct packed {
        logic        en, det, rdy, clr, v;
        logic [15:0] d;
        logic [3:0]  f;
        logic [15:0] c;
    } vec_t;

    vec_t        tv[$];
    logic [15:0] sbq[$];
    logic [15:0] ts_m, cnt_m, gap_m;
    logic        ovf_m;

    function automatic vec_t mk(input bit e, d, r, c, v, input int dd, ff, cc);
        return '{en: e, det: d, rdy: r, clr: c, v: v, d: 16'(dd), f: 4'(ff), c: 16'(cc)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set0(input logic e, d, r, c);
        b0.en = e; b0.det_in = d; b0.rd_ready = r; b0.clr = c;
    endtask

    task automatic set1(input logic e, d, r);
        b1.en = e; b1.det_in = d; b1.rd_ready = r; b1.clr = 1'b0;
    endtask

    task automatic model_clear();
        sbq.delete(); ts_m = '0; cnt_m = '0; gap_m = '0; ovf_m = 1'b0;
    endtask

    // One clock edge: scoreboard compares popped heads, then the model advances.
    task automatic tick();
        logic cap, pop;
        logic [15:0] ent;
        cap = !b0.clr && b0.en && b0.det_in;
        pop = !b0.clr && sbq.size() != 0 && b0.rd_ready;
        ent = GAP ? gap_m : ts_m;
        chk("valid_pre", b0.rd_valid, sbq.size() != 0);
        if (pop) chk("sb_head", b0.rd_data, sbq[0]);
        @(posedge clk);
        if (b0.clr) model_clear();
        else begin
            if (pop) void'(sbq.pop_front());
            if (cap) begin
                if (sbq.size() < 8) sbq.push_back(ent);
                else ovf_m = 1'b1;
                if (cnt_m != 16'hffff) cnt_m = cnt_m + 16'd1;
            end
            gap_m = cap ? 16'd1 : (b0.en && gap_m != 16'hffff) ? gap_m + 16'd1 : gap_m;
            if (b0.en) ts_m = ts_m + 16'd1;
        end
        #1;
        chk("sb_fill", b0.fill, sbq.size());
        chk("sb_count", b0.count, cnt_m);
        chk("sb_overflow", b0.overflow, ovf_m);
        chk("sb_data", b0.rd_data, sbq.size() != 0 ? sbq[0] : 16'd0);
    endtask

    task automatic idle0(input int n, input logic e, d, r);
        for (int i = 0; i < n; i++) begin
            set0(e, d, r, 1'b0);
            tick();
        end
    endtask

    initial begin
        // Test 1: capture at ts=5 and pop; test 2: y of a 101 detector fed x=1,0,1,0,1 from ts=0.
        for (int i = 0; i < 5; i++) tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 1, 5, 1, 1));
        tv.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 1, 2, 1, 1));
        tv.push_back(mk(1, 0, 0, 0, 1, 2, 1, 1));
        tv.push_back(mk(1, 1, 0, 0, 1, 2, 2, 2));
        tv.push_back(mk(1, 0, 1, 0, 1, GAP ? 2 : 4, 1, 2));
        tv.push_back(mk(1, 0, 1, 0, 0, 0, 0, 2));

        set0(1, 1, 1, 0);
        set1(1, 1, 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        chk("rst_valid", b0.rd_valid, 0);
        chk("rst_data", b0.rd_data, 0);
        chk("rst_fill", b0.fill, 0);
        chk("rst_count", b0.count, 0);
        chk("rst_overflow", b0.overflow, 0);
        chk("rst1_fill", b1.fill, 0);
        chk("rst1_count", b1.count, 0);
        set1(0, 0, 0);
        rst = 1'b1;

        foreach (tv[i]) begin
            set0(tv[i].en, tv[i].det, tv[i].rdy, tv[i].clr);
            tick();
            chk("tv_valid", b0.rd_valid, tv[i].v);
            chk("tv_data", b0.rd_data, tv[i].d);
            chk("tv_fill", b0.fill, tv[i].f);
            chk("tv_count", b0.count, tv[i].c);
        end

        // Test 3: nine captures into an eight-deep FIFO, then drain.
        set0(0, 0, 0, 1); tick();
        idle0(9, 1, 1, 0);
        chk("t3_fill", b0.fill, 8);
        chk("t3_overflow", b0.overflow, 1);
        chk("t3_count", b0.count, 9);
        idle0(8, 1, 0, 1);
        chk("t3_empty", b0.fill, 0);
        chk("t3_sticky", b0.overflow, 1);
        idle0(2, 0, 0, 0);
        chk("t3_sticky2", b0.overflow, 1);

        // Test 4: full FIFO with capture and pop on the same edge.
        set0(0, 0, 0, 1); tick();
        chk("t4_clr_ovf", b0.overflow, 0);
        idle0(8, 1, 1, 0);
        set0(1, 1, 1, 0); tick();
        chk("t4_fill", b0.fill, 8);
        chk("t4_overflow", b0.overflow, 0);
        chk("t4_head", b0.rd_data, 1);
        idle0(8, 1, 0, 1);
        chk("t4_drained", b0.fill, 0);

        // Test 5: narrow instance, timestamp wrap and count saturation.
        set0(0, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin set1(1, 0, 0); tick(); end
        set1(1, 1, 0); tick();
        chk("t5_d15", b1.rd_data, 15);
        chk("t5_f1", b1.fill, 1);
        chk("t5_c1", b1.count, 1);
        tick();
        chk("t5_c2", b1.count, 2);
        chk("t5_f2", b1.fill, 2);
        set1(1, 0, 1); tick();
        chk("t5_wrap", b1.rd_data, GAP ? 1 : 0);
        chk("t5_f_pop", b1.fill, 1);
        set1(1, 1, 0);
        repeat (3) tick();
        chk("t5_sat", b1.count, 3);
        chk("t5_full", b1.fill, 4);
        chk("t5_noovf", b1.overflow, 0);
        tick();
        chk("t5_sat2", b1.count, 3);
        chk("t5_ovf", b1.overflow, 1);
        chk("t5_keep", b1.rd_data, GAP ? 1 : 0);
        set1(0, 0, 0);

        // Test 6: clear with a coincident detection, then captures 3, 4 and 10 cycles in.
        set0(0, 0, 0, 1); tick();
        idle0(3, 1, 1, 0);
        chk("t6_pre", b0.fill, 3);
        set0(1, 1, 1, 1); tick();
        chk("t6_fill", b0.fill, 0);
        chk("t6_count", b0.count, 0);
        chk("t6_ovf", b0.overflow, 0);
        chk("t6_valid", b0.rd_valid, 0);
        idle0(3, 1, 0, 0);
        idle0(2, 1, 1, 0);
        idle0(5, 1, 0, 0);
        idle0(1, 1, 1, 0);
        chk("t6_e1", b0.rd_data, 3);
        idle0(1, 1, 0, 1);
        chk("t6_e2", b0.rd_data, GAP ? 1 : 4);
        idle0(1, 1, 0, 1);
        chk("t6_e3", b0.rd_data, GAP ? 6 : 10);
        idle0(1, 1, 0, 1);
        chk("t6_end", b0.rd_valid, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
